// File: rtl/home_room_ctrl.sv
// Room light/door state controller: takes one command at a time, redraws the changed icon(s), then strobes an audio code.
// Latency: accept edge to aud_valid is 3 cycles minimum (APPLY, DRAW, DONE); the DRAW time depends on the drawer; an all-lock draws every room.
// Backpressure: cmd_ready is high only in IDLE, and the source holds cmd_valid/clear_req until accepted; draw_req stays high until draw_done.
module home_room_ctrl #(
    parameter int NUM_ROOMS = 5,
    parameter int ROOM_W    = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int AUD_W     = 4,
    parameter int X0        = 8,
    parameter int PITCH_X   = 28,
    parameter int Y_LIGHT   = 30,
    parameter int Y_DOOR    = 70
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ROOM_W-1:0]    cmd_room,
    input  logic                 cmd_funct,
    input  logic                 cmd_on,
    input  logic                 cmd_all_lock,
    input  logic                 clear_req,
    output logic                 draw_req,
    output logic [X_W-1:0]       draw_x,
    output logic [Y_W-1:0]       draw_y,
    output logic [2:0]           draw_colour,
    output logic                 draw_clear,
    input  logic                 draw_done,
    output logic                 aud_valid,
    output logic [AUD_W-1:0]     aud_code,
    output logic [NUM_ROOMS-1:0] light_state,
    output logic [NUM_ROOMS-1:0] door_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        DRAW  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    typedef struct packed {
        logic [ROOM_W-1:0] room;
        logic              funct;
        logic              on;
        logic              all_lock;
    } cmd_t;

    localparam logic [AUD_W-1:0] AUD_LIGHT_ON  = AUD_W'(0);
    localparam logic [AUD_W-1:0] AUD_LIGHT_OFF = AUD_W'(1);
    localparam logic [AUD_W-1:0] AUD_DOOR_LOCK = AUD_W'(2);
    localparam logic [AUD_W-1:0] AUD_DOOR_OPEN = AUD_W'(3);
    localparam logic [AUD_W-1:0] AUD_ALL_LOCK  = AUD_W'(4);
    localparam logic [AUD_W-1:0] AUD_ERROR     = AUD_W'(5);

    localparam logic [2:0] COL_LIGHT_ON  = 3'b110;
    localparam logic [2:0] COL_LIGHT_OFF = 3'b000;
    localparam logic [2:0] COL_DOOR_LOCK = 3'b100;
    localparam logic [2:0] COL_DOOR_OPEN = 3'b010;

    localparam logic [ROOM_W-1:0] LAST_ROOM = ROOM_W'(NUM_ROOMS - 1);

    state_t                state_q,    state_d;
    cmd_t                  cmd_q,      cmd_d;
    logic [ROOM_W-1:0]     cnt_q,      cnt_d;
    logic [NUM_ROOMS-1:0]  light_q,    light_d;
    logic [NUM_ROOMS-1:0]  door_q,     door_d;
    logic [AUD_W-1:0]      aud_code_q, aud_code_d;

    logic                  room_bad;
    logic [ROOM_W-1:0]     draw_room;

    function automatic logic [AUD_W-1:0] single_code(input cmd_t c);
        if (c.funct) begin
            return c.on ? AUD_LIGHT_ON : AUD_LIGHT_OFF;
        end
        return c.on ? AUD_DOOR_LOCK : AUD_DOOR_OPEN;
    endfunction

    assign room_bad = 32'(cmd_q.room) >= 32'(NUM_ROOMS);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        light_d    = light_q;
        door_d     = door_q;
        aud_code_d = aud_code_q;

        case (state_q)
            IDLE: begin
                // Clear wins over a simultaneous command; the command stays pending.
                if (clear_req) begin
                    state_d = CLEAR;
                end else if (cmd_valid) begin
                    cmd_d.room     = cmd_room;
                    cmd_d.funct    = cmd_funct;
                    cmd_d.on       = cmd_on;
                    cmd_d.all_lock = cmd_all_lock;
                    state_d        = APPLY;
                end
            end
            APPLY: begin
                if (cmd_q.all_lock) begin
                    door_d  = '1;
                    cnt_d   = '0;
                    state_d = DRAW;
                end else if (room_bad) begin
                    aud_code_d = AUD_ERROR;
                    state_d    = DONE;
                end else begin
                    for (int i = 0; i < NUM_ROOMS; i++) begin
                        if (cmd_q.room == ROOM_W'(i)) begin
                            if (cmd_q.funct) begin
                                light_d[i] = cmd_q.on;
                            end else begin
                                door_d[i] = cmd_q.on;
                            end
                        end
                    end
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (draw_done) begin
                    if (cmd_q.all_lock) begin
                        state_d = NEXT;
                    end else begin
                        aud_code_d = single_code(cmd_q);
                        state_d    = DONE;
                    end
                end
            end
            NEXT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ROOM) begin
                    aud_code_d = AUD_ALL_LOCK;
                    state_d    = DONE;
                end else begin
                    state_d = DRAW;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            CLEAR: begin
                if (draw_done) begin
                    light_d = '0;
                    door_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign draw_room = cmd_q.all_lock ? cnt_q : cmd_q.room;

    always_comb begin
        cmd_ready   = (state_q == IDLE);
        draw_req    = (state_q == DRAW) || (state_q == CLEAR);
        draw_clear  = (state_q == CLEAR);
        aud_valid   = (state_q == DONE);
        draw_x      = '0;
        draw_y      = '0;
        draw_colour = 3'b000;
        // Coordinates are only driven while drawing an icon; a clear draws from the origin.
        if (state_q == DRAW) begin
            draw_x = X_W'(32'(X0) + 32'(draw_room) * 32'(PITCH_X));
            if (!cmd_q.all_lock && cmd_q.funct) begin
                draw_y      = Y_W'(Y_LIGHT);
                draw_colour = cmd_q.on ? COL_LIGHT_ON : COL_LIGHT_OFF;
            end else begin
                draw_y      = Y_W'(Y_DOOR);
                draw_colour = (cmd_q.all_lock || cmd_q.on) ? COL_DOOR_LOCK : COL_DOOR_OPEN;
            end
        end
    end

    assign aud_code    = aud_code_q;
    assign light_state = light_q;
    assign door_state  = door_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            light_q    <= '0;
            door_q     <= '0;
            aud_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            light_q    <= light_d;
            door_q     <= door_d;
            aud_code_q <= aud_code_d;
        end
    end

endmodule

// File: tb/tb_home_room_ctrl.sv
// Directed bench for home_room_ctrl: a drawer responder with programmable done latency,
// inputs driven and outputs sampled on the falling clock edge.
module tb_home_room_ctrl;

    localparam logic LIGHT = 1'b1;
    localparam logic DOOR  = 1'b0;

    logic       clock;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_room;
    logic       cmd_funct;
    logic       cmd_on;
    logic       cmd_all_lock;
    logic       clear_req;
    logic       draw_req;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_colour;
    logic       draw_clear;
    logic       draw_done;
    logic       aud_valid;
    logic [3:0] aud_code;
    logic [4:0] light_state;
    logic [4:0] door_state;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] xs[$];
    logic [6:0] ys[$];
    logic [2:0] cols[$];
    int         req_cyc;
    logic [3:0] aud_seen;
    int         waited;
    bit         got_aud;

    home_room_ctrl dut (
        .clock        (clock),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_room     (cmd_room),
        .cmd_funct    (cmd_funct),
        .cmd_on       (cmd_on),
        .cmd_all_lock (cmd_all_lock),
        .clear_req    (clear_req),
        .draw_req     (draw_req),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_colour  (draw_colour),
        .draw_clear   (draw_clear),
        .draw_done    (draw_done),
        .aud_valid    (aud_valid),
        .aud_code     (aud_code),
        .light_state  (light_state),
        .door_state   (door_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge while IDLE; returns one falling edge later with cmd_valid dropped.
    task automatic send_cmd(input logic [3:0] room, input logic funct, input logic on, input logic all);
        cmd_room     = room;
        cmd_funct    = funct;
        cmd_on       = on;
        cmd_all_lock = all;
        cmd_valid    = 1'b1;
        @(negedge clock);
        cmd_valid    = 1'b0;
    endtask

    // Answers each draw request with draw_done on its lat-th cycle until the audio strobe appears.
    task automatic service(input int lat, input int budget);
        int run;
        run     = 0;
        got_aud = 0;
        waited  = 0;
        for (int c = 0; c < budget && !got_aud; c++) begin
            @(negedge clock);
            waited++;
            draw_done = 1'b0;
            if (aud_valid) begin
                got_aud  = 1;
                aud_seen = aud_code;
            end else if (draw_req) begin
                run++;
                req_cyc++;
                if (run == lat) begin
                    xs.push_back(draw_x);
                    ys.push_back(draw_y);
                    cols.push_back(draw_colour);
                    draw_done = 1'b1;
                    run       = 0;
                end
            end
        end
        draw_done = 1'b0;
        if (!got_aud) chk("aud_timeout", 0, 1);
    endtask

    task automatic clear_log();
        xs.delete();
        ys.delete();
        cols.delete();
        req_cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        bit hit;
        resetn       = 1'b0;
        cmd_valid    = 1'b0;
        cmd_room     = '0;
        cmd_funct    = 1'b0;
        cmd_on       = 1'b0;
        cmd_all_lock = 1'b0;
        clear_req    = 1'b0;
        draw_done    = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_draw_req", draw_req, 0);
        chk("rst_draw_clear", draw_clear, 0);
        chk("rst_draw_x", draw_x, 0);
        chk("rst_light", light_state, 0);
        chk("rst_door", door_state, 0);
        chk("rst_aud_valid", aud_valid, 0);
        chk("rst_aud_code", aud_code, 0);

        // Room 2 light on, drawer answers on the 4th request cycle.
        clear_log();
        send_cmd(4'd2, LIGHT, 1'b1, 1'b0);
        chk("l2_ready_low", cmd_ready, 0);
        service(4, 50);
        chk("l2_req_cycles", req_cyc, 4);
        chk("l2_x", xs[0], 64);
        chk("l2_y", ys[0], 30);
        chk("l2_col", cols[0], 3'b110);
        chk("l2_code", aud_seen, 0);
        chk("l2_wait", waited, 5);
        chk("l2_light", light_state, 5'b00100);
        @(negedge clock);
        chk("l2_ready_back", cmd_ready, 1);
        chk("l2_aud_single", aud_valid, 0);

        // Lock room 3, then unlock it with the minimum-latency drawer.
        clear_log();
        send_cmd(4'd3, DOOR, 1'b1, 1'b0);
        service(1, 50);
        chk("d3_lock_state", door_state, 5'b01000);
        chk("d3_lock_code", aud_seen, 2);
        chk("d3_lock_x", xs[0], 92);
        chk("d3_lock_col", cols[0], 3'b100);
        chk("d3_min_latency", waited, 2);
        @(negedge clock);
        clear_log();
        send_cmd(4'd3, DOOR, 1'b0, 1'b0);
        service(1, 50);
        chk("d3_open_state", door_state, 5'b00000);
        chk("d3_open_y", ys[0], 70);
        chk("d3_open_col", cols[0], 3'b010);
        chk("d3_open_code", aud_seen, 3);
        @(negedge clock);

        // All-lock sweep across the five rooms.
        clear_log();
        send_cmd(4'd0, LIGHT, 1'b0, 1'b1);
        service(2, 100);
        chk("all_draws", xs.size(), 5);
        for (int i = 0; i < 5 && i < xs.size(); i++) begin
            chk($sformatf("all_x%0d", i), xs[i], 8 + 28 * i);
            chk($sformatf("all_y%0d", i), ys[i], 70);
            chk($sformatf("all_col%0d", i), cols[i], 3'b100);
        end
        chk("all_code", aud_seen, 4);
        chk("all_door", door_state, 5'b11111);
        chk("all_light", light_state, 5'b00100);
        @(negedge clock);
        chk("all_aud_single", aud_valid, 0);

        // Out-of-range room: straight to the error strobe, nothing drawn.
        clear_log();
        send_cmd(4'd7, LIGHT, 1'b1, 1'b0);
        service(1, 20);
        chk("bad_req_cycles", req_cyc, 0);
        chk("bad_wait", waited, 1);
        chk("bad_code", aud_seen, 5);
        chk("bad_light", light_state, 5'b00100);
        chk("bad_door", door_state, 5'b11111);
        @(negedge clock);

        // Clear and a command presented together: clear first, command afterwards.
        clear_req    = 1'b1;
        cmd_valid    = 1'b1;
        cmd_room     = 4'd0;
        cmd_funct    = LIGHT;
        cmd_on       = 1'b1;
        cmd_all_lock = 1'b0;
        @(negedge clock);
        clear_req = 1'b0;
        chk("clr_draw_clear", draw_clear, 1);
        chk("clr_draw_req", draw_req, 1);
        chk("clr_x", draw_x, 0);
        chk("clr_y", draw_y, 0);
        chk("clr_col", draw_colour, 0);
        chk("clr_ready", cmd_ready, 0);
        @(negedge clock);
        draw_done = 1'b1;
        @(negedge clock);
        draw_done = 1'b0;
        chk("clr_light", light_state, 0);
        chk("clr_door", door_state, 0);
        chk("clr_no_aud", aud_valid, 0);
        chk("clr_idle_ready", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("clr_cmd_taken", cmd_ready, 0);
        clear_log();
        service(1, 20);
        chk("clr_cmd_code", aud_seen, 0);
        chk("clr_cmd_light", light_state, 5'b00001);
        @(negedge clock);

        // Reset asserted on the first cycle of the third all-lock draw.
        send_cmd(4'd0, DOOR, 1'b0, 1'b1);
        nd  = 0;
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clock);
            draw_done = 1'b0;
            if (draw_req) begin
                nd++;
                if (nd < 3) draw_done = 1'b1;
                else hit = 1;
            end
        end
        if (!hit) chk("rst_mid_timeout", 0, 1);
        resetn = 1'b0;
        #1;
        chk("rstm_draw_req", draw_req, 0);
        chk("rstm_draw_x", draw_x, 0);
        chk("rstm_door", door_state, 0);
        chk("rstm_light", light_state, 0);
        chk("rstm_aud_code", aud_code, 0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            draw_done = 1'b1;
            @(negedge clock);
            draw_done = 1'b0;
            chk($sformatf("rstm_idle_req%0d", i), draw_req, 0);
            chk($sformatf("rstm_idle_aud%0d", i), aud_valid, 0);
            chk($sformatf("rstm_idle_ready%0d", i), cmd_ready, 1);
            chk($sformatf("rstm_idle_door%0d", i), door_state, 0);
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
